// File: rtl/lock_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lock_access_ctrl
// Description : Bit-serial keypad lock sequencer with code check, failed-attempt
//               lockout, timed auto-relock and in-field code reprogramming.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_access_ctrl #(
    parameter int                 CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = CODE_LEN'(4'b1011),
    parameter int                 MAX_ATTEMPTS   = 3,
    parameter int                 LOCKOUT_CYCLES = 16,
    parameter int                 RELOCK_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    input  logic       enter,
    input  logic       clear,
    input  logic       prog_en,
    output logic       locked,
    output logic       unlocked,
    output logic       lockout,
    output logic [2:0] attempts_left,
    output logic       prog_done
);

    localparam int c_cnt_w   = $clog2(CODE_LEN + 1);
    localparam int c_tmr_max = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_zero   = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(CODE_LEN - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one    = c_tmr_w'(1);
    localparam logic [c_tmr_w-1:0] c_relock_end = c_tmr_w'(RELOCK_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_lock_end   = c_tmr_w'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         c_att_max    = 3'(MAX_ATTEMPTS);
    localparam logic [2:0]         c_att_one    = 3'd1;

    localparam logic [2:0] c_entry   = 3'd0;
    localparam logic [2:0] c_check   = 3'd1;
    localparam logic [2:0] c_open    = 3'd2;
    localparam logic [2:0] c_prog    = 3'd3;
    localparam logic [2:0] c_lockout = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [c_cnt_w-1:0]  r_count;
    logic [CODE_LEN-1:0] r_shift;
    logic [CODE_LEN-1:0] r_code;
    logic [c_tmr_w-1:0]  r_relock_tmr;
    logic [c_tmr_w-1:0]  r_lock_tmr;
    logic [2:0]          r_attempts;
    logic                r_prog_done;

    logic [CODE_LEN-1:0] w_shift_in;
    logic                w_last_digit;
    logic                w_match;

    assign w_shift_in   = {r_shift[CODE_LEN-2:0], key_in};
    assign w_last_digit = enter && (r_count == c_last_digit);
    assign w_match      = (r_shift == r_code);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_entry;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_entry: begin
                if (!clear && w_last_digit) begin
                    w_next_state = c_check;
                end
            end
            c_check: begin
                if (w_match) begin
                    w_next_state = c_open;
                end else if (r_attempts > c_att_one) begin
                    w_next_state = c_entry;
                end else begin
                    w_next_state = c_lockout;
                end
            end
            c_open: begin
                if (clear) begin
                    w_next_state = c_entry;
                end else if (prog_en && enter) begin
                    w_next_state = c_prog;
                end else if (r_relock_tmr == c_relock_end) begin
                    w_next_state = c_entry;
                end
            end
            c_prog: begin
                if (clear || w_last_digit) begin
                    w_next_state = c_entry;
                end
            end
            c_lockout: begin
                if (r_lock_tmr == c_lock_end) begin
                    w_next_state = c_entry;
                end
            end
            default: w_next_state = c_entry;
        endcase
    end

    always_comb begin
        locked   = 1'b1;
        unlocked = 1'b0;
        lockout  = 1'b0;
        case (r_state)
            c_open, c_prog: begin
                locked   = 1'b0;
                unlocked = 1'b1;
            end
            c_lockout: lockout = 1'b1;
            default: ;
        endcase
    end

    assign attempts_left = r_attempts;
    assign prog_done     = r_prog_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= c_cnt_zero;
            r_shift      <= '0;
            r_code       <= DEFAULT_CODE;
            r_relock_tmr <= '0;
            r_lock_tmr   <= '0;
            r_attempts   <= c_att_max;
            r_prog_done  <= 1'b0;
        end else begin
            r_prog_done <= 1'b0;
            case (r_state)
                c_entry: begin
                    if (clear) begin
                        r_count <= c_cnt_zero;
                        r_shift <= '0;
                    end else if (enter) begin
                        r_shift <= w_shift_in;
                        r_count <= w_last_digit ? c_cnt_zero : r_count + c_cnt_one;
                    end
                end
                c_check: begin
                    if (w_match) begin
                        r_attempts <= c_att_max;
                    end else if (r_attempts > c_att_one) begin
                        r_attempts <= r_attempts - c_att_one;
                    end else begin
                        r_attempts <= 3'd0;
                    end
                end
                c_open: begin
                    if (!clear && prog_en && enter) begin
                        r_shift <= {{(CODE_LEN-1){1'b0}}, key_in};
                        r_count <= c_cnt_one;
                    end
                end
                c_prog: begin
                    if (clear) begin
                        r_count <= c_cnt_zero;
                        r_shift <= '0;
                    end else if (w_last_digit) begin
                        r_code      <= w_shift_in;
                        r_prog_done <= 1'b1;
                        r_count     <= c_cnt_zero;
                        r_shift     <= '0;
                    end else if (enter) begin
                        r_shift <= w_shift_in;
                        r_count <= r_count + c_cnt_one;
                    end
                end
                c_lockout: begin
                    if (r_lock_tmr == c_lock_end) begin
                        r_attempts <= c_att_max;
                    end
                end
                default: r_count <= c_cnt_zero;
            endcase

            // Relock timer runs in OPEN, holds in PROG and sits at zero elsewhere
            if (r_state == c_open) begin
                r_relock_tmr <= r_relock_tmr + c_tmr_one;
            end else if (r_state != c_prog) begin
                r_relock_tmr <= '0;
            end

            if (r_state == c_lockout) begin
                r_lock_tmr <= r_lock_tmr + c_tmr_one;
            end else begin
                r_lock_tmr <= '0;
            end
        end
    end

endmodule
`default_nettype wire
